// File: rtl/seg7_disp_arbiter_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
package seg7_pkg;

  // Source indices, lower index means higher priority
  localparam int unsigned SRC_ERR  = 0;
  localparam int unsigned SRC_CNT  = 1;
  localparam int unsigned SRC_MENU = 2;

  // Display modes
  localparam logic MODE_OP  = 1'b0;
  localparam logic MODE_NUM = 1'b1;

  // Op-code symbols understood by the display driver
  localparam logic [2:0] OP_T = 3'd0;
  localparam logic [2:0] OP_A = 3'd1;
  localparam logic [2:0] OP_B = 3'd2;
  localparam logic [2:0] OP_C = 3'd3;

  typedef enum logic [1:0] {IDLE, SHOW, LINGER} state_e;

  // Isolate the lowest set bit: the highest-priority active request.
  function automatic logic [2:0] prio_pick(input logic [2:0] req);
    return req & ~(req - 3'd1);
  endfunction

  // Source index of a one-hot owner vector (0 when empty).
  function automatic logic [1:0] onehot_idx(input logic [2:0] oh);
    if (oh[2]) return 2'(SRC_MENU);
    if (oh[1]) return 2'(SRC_CNT);
    return 2'(SRC_ERR);
  endfunction

endpackage

// File: rtl/seg7_disp_arbiter_if.sv
// Request/payload inputs and display-driver outputs of the arbiter.
interface seg7_disp_arbiter_if;
  logic [2:0]  i_req;
  logic [2:0]  i_mode;
  logic [8:0]  i_op_code;
  logic [11:0] i_digit;
  logic [2:0]  i_blink;
  logic [2:0]  o_grant;
  logic        o_en;
  logic        o_disp_mode;
  logic [2:0]  o_op_code;
  logic [3:0]  o_digit_val;
  logic        o_busy;

  modport master (
    output i_req, i_mode, i_op_code, i_digit, i_blink,
    input  o_grant, o_en, o_disp_mode, o_op_code, o_digit_val, o_busy
  );

  modport slave (
    input  i_req, i_mode, i_op_code, i_digit, i_blink,
    output o_grant, o_en, o_disp_mode, o_op_code, o_digit_val, o_busy
  );
endinterface

// File: rtl/seg7_blink_gen.sv
// Blink phase generator: phase toggles every BLINK_HALF enabled cycles.
module seg7_blink_gen #(
  parameter int unsigned BLINK_HALF = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_restart,
  input  logic i_en,
  output logic o_phase  // value the phase register takes at the coming edge
);

  localparam int unsigned CntW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            phase_q, phase_d;

  // Restart forces the "on" phase; otherwise count out each half period
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (i_restart) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (i_en) begin
      if (cnt_q == CntW'(BLINK_HALF - 1)) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  assign o_phase = phase_d;

  // Counter and phase state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/seg7_disp_arbiter.sv
// Fixed-priority arbiter sharing one seven-segment driver among three sources,
// with minimum hold time, optional blinking and registered outputs.
import seg7_pkg::*;

module seg7_disp_arbiter #(
  parameter int unsigned HOLD_CYCLES = 50_000_000,
  parameter int unsigned BLINK_HALF  = 25_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  seg7_disp_arbiter_if.slave  bus
);

  localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HoldW-1:0] HoldLoad = HoldW'(HOLD_CYCLES - 1);

  state_e           state_q, state_d;
  logic [2:0]       owner_q, owner_d;
  logic [HoldW-1:0] hold_q, hold_d, hold_dec;
  logic [2:0]       grant_q, grant_d;
  logic             en_q, en_d;
  logic             mode_q, mode_d;
  logic [2:0]       op_q, op_d;
  logic [3:0]       digit_q, digit_d;
  logic             blink_q, blink_d;
  logic [2:0]       win;
  logic             any_req, owner_req, higher, take, phase_nxt;
  logic [1:0]       nidx;

  // Arbitration FSM: decides owner, state and hold counter for the next cycle
  always_comb begin
    win       = prio_pick(bus.i_req);
    any_req   = |bus.i_req;
    owner_req = |(bus.i_req & owner_q);
    higher    = |(bus.i_req & (owner_q - 3'd1));  // bits below the owner's are stronger
    hold_dec  = (hold_q == '0) ? '0 : hold_q - HoldW'(1);
    state_d   = state_q;
    owner_d   = owner_q;
    hold_d    = hold_q;
    take      = 1'b0;
    unique case (state_q)
      IDLE: take = any_req;
      SHOW: begin
        if (higher) begin
          take = 1'b1;
        end else if (owner_req) begin
          hold_d = hold_dec;
        end else if (hold_q != '0) begin
          state_d = LINGER;
          hold_d  = hold_dec;
        end else if (any_req) begin
          take = 1'b1;
        end else begin
          state_d = IDLE;
          owner_d = '0;
        end
      end
      LINGER: begin
        if (higher) begin
          take = 1'b1;
        end else if (owner_req) begin
          state_d = SHOW;  // returning owner keeps its remaining hold time
          hold_d  = hold_dec;
        end else if (hold_q != '0) begin
          hold_d = hold_dec;
        end else if (any_req) begin
          take = 1'b1;
        end else begin
          state_d = IDLE;
          owner_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        owner_d = '0;
        hold_d  = '0;
      end
    endcase
    if (take) begin
      state_d = SHOW;
      owner_d = win;
      hold_d  = HoldLoad;
    end
  end

  seg7_blink_gen #(
    .BLINK_HALF (BLINK_HALF)
  ) u_blink (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_restart (take),
    .i_en      (state_d != IDLE),
    .o_phase   (phase_nxt)
  );

  // Output payload: track the owner in SHOW, freeze in LINGER, blank in IDLE
  always_comb begin
    nidx    = onehot_idx(owner_d);
    grant_d = '0;
    mode_d  = mode_q;
    op_d    = op_q;
    digit_d = digit_q;
    blink_d = blink_q;
    unique case (state_d)
      SHOW: begin
        grant_d = owner_d;
        case (nidx)
          2'd1: begin
            mode_d  = bus.i_mode[1];
            op_d    = bus.i_op_code[5:3];
            digit_d = bus.i_digit[7:4];
            blink_d = bus.i_blink[1];
          end
          2'd2: begin
            mode_d  = bus.i_mode[2];
            op_d    = bus.i_op_code[8:6];
            digit_d = bus.i_digit[11:8];
            blink_d = bus.i_blink[2];
          end
          default: begin
            mode_d  = bus.i_mode[0];
            op_d    = bus.i_op_code[2:0];
            digit_d = bus.i_digit[3:0];
            blink_d = bus.i_blink[0];
          end
        endcase
      end
      LINGER: ;
      default: begin
        mode_d  = 1'b0;
        op_d    = '0;
        digit_d = '0;
        blink_d = 1'b0;
      end
    endcase
    en_d = (state_d != IDLE) && (!blink_d || phase_nxt);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      hold_q  <= '0;
      grant_q <= '0;
      en_q    <= 1'b0;
      mode_q  <= 1'b0;
      op_q    <= '0;
      digit_q <= '0;
      blink_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      hold_q  <= hold_d;
      grant_q <= grant_d;
      en_q    <= en_d;
      mode_q  <= mode_d;
      op_q    <= op_d;
      digit_q <= digit_d;
      blink_q <= blink_d;
    end
  end

  assign bus.o_grant     = grant_q;
  assign bus.o_en        = en_q;
  assign bus.o_disp_mode = mode_q;
  assign bus.o_op_code   = op_q;
  assign bus.o_digit_val = digit_q;
  assign bus.o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_seg7_disp_arbiter.sv
// Directed bench for seg7_disp_arbiter with HOLD_CYCLES=8, BLINK_HALF=4.
module tb_seg7_disp_arbiter;
  import seg7_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;

  seg7_disp_arbiter_if bus();

  seg7_disp_arbiter #(
    .HOLD_CYCLES (8),
    .BLINK_HALF  (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int k, input logic mode, input logic [2:0] op,
                         input logic [3:0] dig, input logic blk);
    bus.i_mode[k]  = mode;
    bus.i_blink[k] = blk;
    case (k)
      1: begin bus.i_op_code[5:3] = op; bus.i_digit[7:4] = dig; end
      2: begin bus.i_op_code[8:6] = op; bus.i_digit[11:8] = dig; end
      default: begin bus.i_op_code[2:0] = op; bus.i_digit[3:0] = dig; end
    endcase
  endtask

  task automatic clear_inputs();
    bus.i_req = '0; bus.i_mode = '0; bus.i_op_code = '0; bus.i_digit = '0; bus.i_blink = '0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    clear_inputs();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    bus.i_req = 3'b111;
    tick();
    total++; if (bus.o_grant !== 3'b000) begin bad++; $display("FAIL reset_grant got=%b want=000", bus.o_grant); end
    total++; if (bus.o_en !== 1'b0) begin bad++; $display("FAIL reset_en got=%b want=0", bus.o_en); end
    total++; if (bus.o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.o_busy); end
    total++; if (bus.o_disp_mode !== 1'b0) begin bad++; $display("FAIL reset_mode got=%b want=0", bus.o_disp_mode); end
    total++; if (bus.o_op_code !== 3'd0) begin bad++; $display("FAIL reset_op got=%0d want=0", bus.o_op_code); end
    total++; if (bus.o_digit_val !== 4'd0) begin bad++; $display("FAIL reset_digit got=%0d want=0", bus.o_digit_val); end
    bus.i_req = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_menu_grant_preempt();
    apply_reset();
    set_src(SRC_MENU, MODE_OP, OP_A, 4'd3, 1'b0);
    bus.i_req = 3'b100;
    total++; if (bus.o_grant !== 3'b000) begin bad++; $display("FAIL grant_latency got=%b want=000", bus.o_grant); end
    tick();
    total++; if (bus.o_grant !== 3'b100) begin bad++; $display("FAIL menu_grant got=%b want=100", bus.o_grant); end
    total++; if (bus.o_en !== 1'b1) begin bad++; $display("FAIL menu_en got=%b want=1", bus.o_en); end
    total++; if (bus.o_disp_mode !== MODE_OP) begin bad++; $display("FAIL menu_mode got=%b want=0", bus.o_disp_mode); end
    total++; if (bus.o_op_code !== OP_A) begin bad++; $display("FAIL menu_op got=%0d want=1", bus.o_op_code); end
    total++; if (bus.o_busy !== 1'b1) begin bad++; $display("FAIL menu_busy got=%b want=1", bus.o_busy); end
    // payload change by owner, out-of-range values pass through
    set_src(SRC_MENU, MODE_NUM, 3'd7, 4'd15, 1'b0);
    tick();
    total++; if (bus.o_op_code !== 3'd7) begin bad++; $display("FAIL payload_op got=%0d want=7", bus.o_op_code); end
    total++; if (bus.o_digit_val !== 4'd15) begin bad++; $display("FAIL payload_digit got=%0d want=15", bus.o_digit_val); end
    total++; if (bus.o_disp_mode !== MODE_NUM) begin bad++; $display("FAIL payload_mode got=%b want=1", bus.o_disp_mode); end
    set_src(SRC_ERR, MODE_NUM, OP_T, 4'd12, 1'b0);
    bus.i_req = 3'b101;
    total++; if (bus.o_grant !== 3'b100) begin bad++; $display("FAIL preempt_nogap got=%b want=100", bus.o_grant); end
    tick();
    total++; if (bus.o_grant !== 3'b001) begin bad++; $display("FAIL preempt_grant got=%b want=001", bus.o_grant); end
    total++; if (bus.o_digit_val !== 4'd12) begin bad++; $display("FAIL preempt_digit got=%0d want=12", bus.o_digit_val); end
    total++; if (bus.o_en !== 1'b1) begin bad++; $display("FAIL preempt_en got=%b want=1", bus.o_en); end
  endtask

  task automatic test_linger();
    logic want;
    apply_reset();
    set_src(SRC_CNT, MODE_NUM, OP_T, 4'd7, 1'b0);
    bus.i_req = 3'b010;
    tick();
    total++; if (bus.o_grant !== 3'b010) begin bad++; $display("FAIL cnt_grant got=%b want=010", bus.o_grant); end
    tick();
    bus.i_req = 3'b000;
    for (int k = 3; k <= 9; k++) begin
      tick();
      want = (k <= 8);
      total++; if (bus.o_en !== want) begin bad++; $display("FAIL linger_en cyc=%0d got=%b want=%b", k, bus.o_en, want); end
      total++; if (bus.o_grant !== 3'b000) begin bad++; $display("FAIL linger_grant cyc=%0d got=%b want=000", k, bus.o_grant); end
      total++; if (bus.o_busy !== want) begin bad++; $display("FAIL linger_busy cyc=%0d got=%b want=%b", k, bus.o_busy, want); end
      if (k <= 8) begin
        total++; if (bus.o_digit_val !== 4'd7) begin bad++; $display("FAIL linger_frozen cyc=%0d got=%0d want=7", k, bus.o_digit_val); end
      end
    end
  endtask

  task automatic test_linger_lower();
    apply_reset();
    set_src(SRC_CNT, MODE_NUM, OP_T, 4'd7, 1'b0);
    set_src(SRC_MENU, MODE_OP, OP_C, 4'd0, 1'b0);
    bus.i_req = 3'b010;
    tick();
    tick();
    bus.i_req = 3'b000;
    tick();
    bus.i_req = 3'b100;
    for (int k = 4; k <= 8; k++) begin
      tick();
      total++; if (bus.o_grant !== 3'b000) begin bad++; $display("FAIL lower_wait cyc=%0d got=%b want=000", k, bus.o_grant); end
      total++; if (bus.o_en !== 1'b1) begin bad++; $display("FAIL lower_wait_en cyc=%0d got=%b want=1", k, bus.o_en); end
    end
    tick();
    total++; if (bus.o_grant !== 3'b100) begin bad++; $display("FAIL lower_grant got=%b want=100", bus.o_grant); end
    total++; if (bus.o_op_code !== OP_C) begin bad++; $display("FAIL lower_op got=%0d want=3", bus.o_op_code); end
  endtask

  task automatic test_blink();
    logic want;
    apply_reset();
    set_src(SRC_MENU, MODE_OP, OP_B, 4'd0, 1'b1);
    set_src(SRC_ERR, MODE_NUM, OP_T, 4'd9, 1'b1);
    bus.i_req = 3'b100;
    tick();
    total++; if (bus.o_en !== 1'b1) begin bad++; $display("FAIL blink_menu_first got=%b want=1", bus.o_en); end
    bus.i_req = 3'b101;
    for (int i = 0; i < 12; i++) begin
      tick();
      want = (i < 4) || (i >= 8);
      total++; if (bus.o_en !== want) begin bad++; $display("FAIL blink_err_en i=%0d got=%b want=%b", i, bus.o_en, want); end
      total++; if (bus.o_grant !== 3'b001) begin bad++; $display("FAIL blink_err_grant i=%0d got=%b want=001", i, bus.o_grant); end
    end
    bus.i_req = 3'b100;
    for (int i = 0; i < 5; i++) begin
      tick();
      want = (i < 4);
      total++; if (bus.o_en !== want) begin bad++; $display("FAIL blink_menu_en i=%0d got=%b want=%b", i, bus.o_en, want); end
      total++; if (bus.o_grant !== 3'b100) begin bad++; $display("FAIL blink_menu_grant i=%0d got=%b want=100", i, bus.o_grant); end
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    set_src(SRC_CNT, MODE_NUM, OP_T, 4'd4, 1'b0);
    set_src(SRC_ERR, MODE_NUM, OP_T, 4'd1, 1'b0);
    bus.i_req = 3'b010;
    tick();
    total++; if (bus.o_grant !== 3'b010) begin bad++; $display("FAIL b2b_first got=%b want=010", bus.o_grant); end
    bus.i_req = 3'b001;  // owner drops while error rises
    tick();
    total++; if (bus.o_grant !== 3'b001) begin bad++; $display("FAIL b2b_grant got=%b want=001", bus.o_grant); end
    total++; if (bus.o_digit_val !== 4'd1) begin bad++; $display("FAIL b2b_digit got=%0d want=1", bus.o_digit_val); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    set_src(SRC_MENU, MODE_NUM, OP_A, 4'd2, 1'b0);
    bus.i_req = 3'b100;
    tick();
    total++; if (bus.o_grant !== 3'b100) begin bad++; $display("FAIL ar_pre got=%b want=100", bus.o_grant); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (bus.o_grant !== 3'b000) begin bad++; $display("FAIL ar_grant got=%b want=000", bus.o_grant); end
    total++; if (bus.o_en !== 1'b0) begin bad++; $display("FAIL ar_en got=%b want=0", bus.o_en); end
    total++; if (bus.o_busy !== 1'b0) begin bad++; $display("FAIL ar_busy got=%b want=0", bus.o_busy); end
    total++; if (bus.o_digit_val !== 4'd0) begin bad++; $display("FAIL ar_digit got=%0d want=0", bus.o_digit_val); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (bus.o_grant !== 3'b000) begin bad++; $display("FAIL ar_release got=%b want=000", bus.o_grant); end
    tick();
    total++; if (bus.o_grant !== 3'b100) begin bad++; $display("FAIL ar_regrant got=%b want=100", bus.o_grant); end
    total++; if (bus.o_en !== 1'b1) begin bad++; $display("FAIL ar_regrant_en got=%b want=1", bus.o_en); end
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    test_reset();
    test_menu_grant_preempt();
    test_linger();
    test_linger_lower();
    test_blink();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
